// File: rtl/joy_snapshot_pkg.sv
// joy_snapshot_pkg: shared types, sizes and byte packing for the joystick snapshot block
package joy_snapshot_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, FRAME} state_t;
  typedef enum logic [1:0] {G_NONE, G_DN, G_SNAP, G_CPU} gsel_t;
  localparam int SNAP_BYTES = 37;
  localparam int BYTES_PER_PLAYER = 6;
  localparam int CAP_BYTES = SNAP_BYTES - 1;
  // Per player: joystick word LSB first, then analog X, then analog Y.
  function automatic logic [8*CAP_BYTES-1:0] pack_snapshot(input logic [191:0] joy, input logic [95:0] an);
    logic [8*CAP_BYTES-1:0] r;
    r = '0;
    for (int p = 0; p < 6; p++) r[p*8*BYTES_PER_PLAYER +: 8*BYTES_PER_PLAYER] = {an[p*16 +: 16], joy[p*32 +: 32]};
    return r;
  endfunction
endpackage

// File: rtl/ram_port_arb.sv
// ram_port_arb: fixed-priority arbiter for the shared work RAM port with registered outputs and CPU ack pipeline
module ram_port_arb #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              snap_req,
  input  logic [ADDR_W-1:0] snap_addr,
  input  logic [7:0]        snap_data,
  output logic              snap_gnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  import joy_snapshot_pkg::*;
  gsel_t gsel;
  logic cpu_s1, s1_rd, ack_rd;
  logic [7:0] rdata_q;
  // Download never waits; the CPU is locked out while its own access is in flight.
  always_comb begin
    gsel = dn_wr ? G_DN : snap_req ? G_SNAP : (cpu_req & ~cpu_s1 & ~cpu_ack) ? G_CPU : G_NONE;
    snap_gnt = (gsel == G_SNAP);
    cpu_rdata = ack_rd ? ram_rdata : rdata_q;
  end
  // Register the winner onto the RAM port and track the CPU access to its ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      cpu_s1 <= 1'b0;
      s1_rd <= 1'b0;
      cpu_ack <= 1'b0;
      ack_rd <= 1'b0;
      rdata_q <= '0;
    end else begin
      ram_we <= (gsel == G_DN) || (gsel == G_SNAP) || ((gsel == G_CPU) && cpu_we);
      if (gsel != G_NONE) begin
        ram_addr <= (gsel == G_DN) ? dn_addr : (gsel == G_SNAP) ? snap_addr : cpu_addr;
        ram_wdata <= (gsel == G_DN) ? dn_data : (gsel == G_SNAP) ? snap_data : cpu_wdata;
      end
      cpu_s1 <= (gsel == G_CPU);
      s1_rd <= (gsel == G_CPU) && !cpu_we;
      cpu_ack <= cpu_s1;
      ack_rd <= s1_rd;
      rdata_q <= cpu_rdata;
    end
  end
endmodule

// File: rtl/joy_snapshot_arb.sv
// joy_snapshot_arb: once-per-frame coherent input snapshot into shared work RAM
module joy_snapshot_arb #(
  parameter int              ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] SNAP_BASE = 14'h3F00,
  parameter int              PLAYERS   = 6
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  vblank,
  input  logic [32*PLAYERS-1:0] joystick,
  input  logic [16*PLAYERS-1:0] analog,
  input  logic                  dn_active,
  input  logic                  dn_wr,
  input  logic [ADDR_W-1:0]     dn_addr,
  input  logic [7:0]            dn_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [7:0]            frame_cnt
);
  import joy_snapshot_pkg::*;
  localparam logic [5:0] LAST = 6'(BYTES_PER_PLAYER * PLAYERS - 1);
  state_t state, nstate;
  logic [5:0] idx;
  logic [8*CAP_BYTES-1:0] cap;
  logic vblank_d, vrise, start, snap_req, snap_gnt;
  logic [ADDR_W-1:0] snap_addr;
  logic [7:0] snap_data;
  assign vrise = vblank & ~vblank_d;
  assign start = (state == IDLE) & vrise & ~dn_active;
  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nstate;
  end
  // Advance only on granted cycles so contention just stretches the snapshot.
  always_comb begin
    nstate = (state == IDLE) ? (start ? WRITE : IDLE) :
             (state == WRITE) ? ((snap_gnt && idx == LAST) ? FRAME : WRITE) :
             (state == FRAME && !snap_gnt) ? FRAME : IDLE;
  end
  // Engine request, address and byte; idx reaches 36 exactly when FRAME writes the counter.
  always_comb begin
    busy = (state != IDLE);
    snap_req = busy;
    snap_addr = SNAP_BASE + ADDR_W'(idx);
    snap_data = (state == FRAME) ? frame_cnt : cap[{idx, 3'b000} +: 8];
  end
  // Capture, byte index, frame counter and sticky overrun (set beats clear).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vblank_d <= 1'b0;
      cap <= '0;
      idx <= '0;
      frame_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      vblank_d <= vblank;
      overrun <= (vrise & busy) | (overrun & ~overrun_clr);
      if (start) begin
        cap <= pack_snapshot(joystick, analog);
        frame_cnt <= frame_cnt + 8'd1;
        idx <= '0;
      end else if (snap_gnt) idx <= idx + 6'd1;
    end
  end
  ram_port_arb #(.ADDR_W(ADDR_W)) u_arb (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .snap_req(snap_req), .snap_addr(snap_addr), .snap_data(snap_data), .snap_gnt(snap_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
endmodule

// File: tb/tb_joy_snapshot_arb.sv
// tb_joy_snapshot_arb: directed self-checking bench with a behavioural work RAM
module tb_joy_snapshot_arb;
  localparam logic [13:0] SB = 14'h3F00;
  logic clk_sys = 0, reset_n = 0, vblank = 0, dn_active = 0, dn_wr = 0;
  logic [191:0] joystick = '0;
  logic [95:0] analog = '0;
  logic [13:0] dn_addr = '0, cpu_addr = '0;
  logic [7:0] dn_data = '0, cpu_wdata = '0;
  logic cpu_req = 0, cpu_we = 0, overrun_clr = 0;
  logic cpu_ack, ram_we, busy, overrun;
  logic [7:0] cpu_rdata, ram_wdata, frame_cnt;
  logic [7:0] ram_rdata = '0;
  logic [13:0] ram_addr;
  logic [7:0] mem [0:16383];
  logic [31:0] ej [6];
  logic [15:0] ea [6];
  int checks = 0, errors = 0;
  typedef struct { string name; logic [13:0] addr; logic [7:0] exp; } vec_t;
  vec_t tab [13];

  joy_snapshot_arb dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .vblank(vblank), .joystick(joystick), .analog(analog),
    .dn_active(dn_active), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .overrun(overrun),
    .overrun_clr(overrun_clr), .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < 6; p++) begin
      joystick[p*32 +: 32] = ej[p];
      analog[p*16 +: 16] = ea[p];
    end
  endtask

  function automatic logic [7:0] exp_byte(input int off, input logic [7:0] fc);
    int p, b;
    p = off / 6;
    b = off % 6;
    if (off == 36) return fc;
    if (b < 4) return 8'(ej[p] >> (8 * b));
    return 8'(ea[p] >> (8 * (b - 4)));
  endfunction

  task automatic check_snapshot(input string tag, input logic [7:0] fc);
    for (int o = 0; o < 37; o++)
      chk($sformatf("%s_byte%0d", tag, o), {24'd0, mem[SB + 14'(o)]}, {24'd0, exp_byte(o, fc)});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(n < 200), 1);
    tick();
    tick();
  endtask

  task automatic start_snap();
    vblank = 1;
    tick();
    vblank = 0;
  endtask

  initial begin
    int n, t, wr;
    tab[0] = '{"j0_b0", SB + 14'd0, 8'hD4};
    tab[1] = '{"j0_b1", SB + 14'd1, 8'hC3};
    tab[2] = '{"j0_b2", SB + 14'd2, 8'hB2};
    tab[3] = '{"j0_b3", SB + 14'd3, 8'hA1};
    tab[4] = '{"an0_x", SB + 14'd4, 8'h80};
    tab[5] = '{"an0_y", SB + 14'd5, 8'h7F};
    tab[6] = '{"j5_b0", SB + 14'd30, 8'h44};
    tab[7] = '{"j5_b1", SB + 14'd31, 8'h33};
    tab[8] = '{"j5_b2", SB + 14'd32, 8'h22};
    tab[9] = '{"j5_b3", SB + 14'd33, 8'h11};
    tab[10] = '{"an5_x", SB + 14'd34, 8'h66};
    tab[11] = '{"an5_y", SB + 14'd35, 8'h55};
    tab[12] = '{"frame", SB + 14'd36, 8'h01};
    #2;
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_ram_addr", {18'd0, ram_addr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame", {24'd0, frame_cnt}, 0);
    chk("rst_ack", {31'd0, cpu_ack}, 0);
    #10 reset_n = 1;
    tick();

    // Test 1: uncontended snapshot, layout and duration.
    for (int p = 0; p < 6; p++) begin
      ej[p] = 32'h10203040 + 32'(p);
      ea[p] = 16'h0A00 + 16'(p);
    end
    ej[0] = 32'hA1B2C3D4; ea[0] = 16'h7F80;
    ej[5] = 32'h11223344; ea[5] = 16'h5566;
    drive_inputs();
    start_snap();
    chk("t1_frame_cnt", {24'd0, frame_cnt}, 1);
    chk("t1_first_we_delay", {31'd0, ram_we}, 0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (n == 1) begin
        chk("t1_first_we", {31'd0, ram_we}, 1);
        chk("t1_first_addr", {18'd0, ram_addr}, {18'd0, SB});
        chk("t1_first_data", {24'd0, ram_wdata}, 32'hD4);
      end
    end
    chk("t1_busy_cycles", n, 37);
    tick();
    tick();
    for (int i = 0; i < 13; i++) chk(tab[i].name, {24'd0, mem[tab[i].addr]}, {24'd0, tab[i].exp});
    check_snapshot("t1", 8'd1);

    // Test 2: inputs scrambled every cycle after capture.
    for (int p = 0; p < 6; p++) begin
      ej[p] = $urandom;
      ea[p] = 16'($urandom);
    end
    drive_inputs();
    start_snap();
    n = 0;
    while (busy && n < 200) begin
      for (int p = 0; p < 6; p++) begin
        joystick[p*32 +: 32] = $urandom;
        analog[p*16 +: 16] = 16'($urandom);
      end
      tick();
      n++;
    end
    tick();
    tick();
    check_snapshot("t2", 8'd2);

    // Test 3a: CPU write of 5A to 0x0010 while idle.
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 8'h5A;
    tick();
    chk("t3w_ram_we", {31'd0, ram_we}, 1);
    chk("t3w_ram_addr", {18'd0, ram_addr}, 32'h10);
    chk("t3w_ram_wdata", {24'd0, ram_wdata}, 32'h5A);
    chk("t3w_no_ack_yet", {31'd0, cpu_ack}, 0);
    tick();
    chk("t3w_ack", {31'd0, cpu_ack}, 1);
    chk("t3w_rdata_unchanged", {24'd0, cpu_rdata}, 0);
    cpu_req = 0; cpu_we = 0;
    tick();
    chk("t3w_ack_pulse", {31'd0, cpu_ack}, 0);

    // Test 3b: CPU read issued two cycles into a snapshot waits for it to finish.
    for (int p = 0; p < 6; p++) begin
      ej[p] = 32'hC0DE0000 + 32'(p * 7);
      ea[p] = 16'hBEE0 + 16'(p);
    end
    drive_inputs();
    start_snap();
    tick();
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
    t = 3;
    while (!cpu_ack && t < 200) begin
      tick();
      t++;
    end
    chk("t3r_ack_cycle", t, 40);
    chk("t3r_rdata", {24'd0, cpu_rdata}, 32'h5A);
    chk("t3r_idle_at_ack", {31'd0, busy}, 0);
    cpu_req = 0;
    tick();
    chk("t3r_ack_pulse", {31'd0, cpu_ack}, 0);
    check_snapshot("t3", 8'd3);

    // Test 4: download pulses every other cycle steal cycles but never stall.
    for (int p = 0; p < 6; p++) begin
      ej[p] = 32'h0F1E2D3C ^ 32'(p << 8);
      ea[p] = 16'h4B5A ^ 16'(p);
    end
    drive_inputs();
    start_snap();
    n = 0;
    while (busy && n < 200) begin
      dn_wr = (n < 20) && (n % 2 == 0);
      dn_addr = 14'h0100 + 14'(n / 2);
      dn_data = 8'hE0 + 8'(n / 2);
      tick();
      n++;
    end
    dn_wr = 0;
    chk("t4_busy_cycles", n, 47);
    tick();
    tick();
    for (int k = 0; k < 10; k++)
      chk($sformatf("t4_dn%0d", k), {24'd0, mem[14'h0100 + 14'(k)]}, 32'hE0 + 32'(k));
    check_snapshot("t4", 8'd4);

    // Test 5: vblank rise during a snapshot sets overrun; set wins over clear.
    for (int p = 0; p < 6; p++) begin
      ej[p] = 32'h55AA0000 | 32'(p);
      ea[p] = 16'h9900 | 16'(p);
    end
    drive_inputs();
    chk("t5_overrun_pre", {31'd0, overrun}, 0);
    start_snap();
    joystick = ~joystick;
    analog = ~analog;
    for (int i = 0; i < 9; i++) tick();
    vblank = 1;
    tick();
    chk("t5_overrun_set", {31'd0, overrun}, 1);
    chk("t5_frame_unchanged", {24'd0, frame_cnt}, 5);
    vblank = 0;
    tick();
    vblank = 1; overrun_clr = 1;
    tick();
    chk("t5_set_beats_clr", {31'd0, overrun}, 1);
    vblank = 0;
    tick();
    overrun_clr = 0;
    chk("t5_clr", {31'd0, overrun}, 0);
    chk("t5_still_busy", {31'd0, busy}, 1);
    wait_idle("t5");
    check_snapshot("t5", 8'd5);

    // Test 6: async reset at idx 20, then fresh snapshot, then dn_active suppression.
    start_snap();
    for (int i = 0; i < 20; i++) tick();
    chk("t6_mid_addr", {18'd0, ram_addr}, {18'd0, SB + 14'd19});
    reset_n = 0;
    #1;
    chk("t6_rst_we", {31'd0, ram_we}, 0);
    chk("t6_rst_addr", {18'd0, ram_addr}, 0);
    chk("t6_rst_wdata", {24'd0, ram_wdata}, 0);
    chk("t6_rst_ack", {31'd0, cpu_ack}, 0);
    chk("t6_rst_rdata", {24'd0, cpu_rdata}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_overrun", {31'd0, overrun}, 0);
    chk("t6_rst_frame", {24'd0, frame_cnt}, 0);
    #2 reset_n = 1;
    tick();
    for (int p = 0; p < 6; p++) begin
      ej[p] = 32'h87654321 + 32'(p * 3);
      ea[p] = 16'h3C3C + 16'(p);
    end
    drive_inputs();
    start_snap();
    chk("t6_frame_after_rst", {24'd0, frame_cnt}, 1);
    wait_idle("t6");
    check_snapshot("t6", 8'd1);
    dn_active = 1;
    vblank = 1;
    wr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vblank = 0;
      wr += 32'(ram_we);
      if (i == 0) chk("t6_dn_active_busy", {31'd0, busy}, 0);
    end
    dn_active = 0;
    chk("t6_dn_active_writes", wr, 0);
    chk("t6_dn_active_frame", {24'd0, frame_cnt}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
